// File: rtl/exu_alu_seq_if.sv
// rtl/exu_alu_seq_if.sv - operand/result handshake bundle for exu_alu_seq
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`define NO_FUNCT     0
`define ADD          1
`define SUB          2
`define SHIFT_L_L    3
`define SHIFT_R_L    4
`define SHIFT_R_A    5
`define XOR          6
`define OR           7
`define AND          8
`define EQ           9
`define NEQ          10
`define LESS         11
`define GREATER_EQ   12
`define LESS_U       13
`define GREATER_EQ_U 14
`endif

interface exu_alu_seq_if #(parameter int DATA_W = `ISA_WIDTH);
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           alu_a;
    logic [DATA_W-1:0]           alu_b;
    logic [`ALU_FUNCT_WIDTH-1:0] alu_funct;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           alu_result;
    logic                        busy;

    modport master (
        output in_valid, alu_a, alu_b, alu_funct, out_ready,
        input  in_ready, out_valid, alu_result, busy
    );

    modport slave (
        input  in_valid, alu_a, alu_b, alu_funct, out_ready,
        output in_ready, out_valid, alu_result, busy
    );
endinterface

// File: rtl/exu_alu_seq.sv
// rtl/exu_alu_seq.sv - execution-stage ALU, single-cycle ops plus 1-bit/cycle shifter
// Optional macro EXU_ALU_FAST_SHIFT_EN: barrel shifter, all ops complete in one cycle.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`define NO_FUNCT     0
`define ADD          1
`define SUB          2
`define SHIFT_L_L    3
`define SHIFT_R_L    4
`define SHIFT_R_A    5
`define XOR          6
`define OR           7
`define AND          8
`define EQ           9
`define NEQ          10
`define LESS         11
`define GREATER_EQ   12
`define LESS_U       13
`define GREATER_EQ_U 14
`endif

module exu_alu_seq #(
    parameter int DATA_W  = `ISA_WIDTH,
    parameter int SHAMT_W = 5
) (
    input logic          clk,
    input logic          rst,
    exu_alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                      state, state_nx;
    logic [DATA_W-1:0]           result, result_nx;
    logic [DATA_W-1:0]           work, work_nx;
    logic [SHAMT_W-1:0]          cnt, cnt_nx;
    logic [`ALU_FUNCT_WIDTH-1:0] funct, funct_nx;
    logic [DATA_W-1:0]           op_res;
    logic [SHAMT_W-1:0]          amt;
    logic                        accept;
    logic                        is_shift;

    function automatic logic [DATA_W-1:0] shift1(input logic [DATA_W-1:0] v,
                                                 input logic [`ALU_FUNCT_WIDTH-1:0] f);
        case (f)
            `SHIFT_L_L: shift1 = {v[DATA_W-2:0], 1'b0};
            `SHIFT_R_L: shift1 = {1'b0, v[DATA_W-1:1]};
            default:    shift1 = {v[DATA_W-1], v[DATA_W-1:1]};
        endcase
    endfunction

    assign amt          = bus.alu_b[SHAMT_W-1:0];
    assign bus.in_ready = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign is_shift     = (bus.alu_funct == `SHIFT_L_L) | (bus.alu_funct == `SHIFT_R_L) |
                          (bus.alu_funct == `SHIFT_R_A);
    assign bus.out_valid  = (state == DONE);
    assign bus.alu_result = result;
`ifdef EXU_ALU_FAST_SHIFT_EN
    assign bus.busy = 1'b0;
`else
    assign bus.busy = (state == SHIFT);
`endif

    always_comb begin
        op_res = '0;
        case (bus.alu_funct)
            `ADD:          op_res = bus.alu_a + bus.alu_b;
            `SUB:          op_res = bus.alu_a - bus.alu_b;
            `XOR:          op_res = bus.alu_a ^ bus.alu_b;
            `OR:           op_res = bus.alu_a | bus.alu_b;
            `AND:          op_res = bus.alu_a & bus.alu_b;
            `EQ:           op_res = {{(DATA_W-1){1'b0}}, bus.alu_a == bus.alu_b};
            `NEQ:          op_res = {{(DATA_W-1){1'b0}}, bus.alu_a != bus.alu_b};
            `LESS:         op_res = {{(DATA_W-1){1'b0}}, $signed(bus.alu_a) < $signed(bus.alu_b)};
            `GREATER_EQ:   op_res = {{(DATA_W-1){1'b0}}, $signed(bus.alu_a) >= $signed(bus.alu_b)};
            `LESS_U:       op_res = {{(DATA_W-1){1'b0}}, bus.alu_a < bus.alu_b};
            `GREATER_EQ_U: op_res = {{(DATA_W-1){1'b0}}, bus.alu_a >= bus.alu_b};
`ifdef EXU_ALU_FAST_SHIFT_EN
            `SHIFT_L_L:    op_res = bus.alu_a << amt;
            `SHIFT_R_L:    op_res = bus.alu_a >> amt;
            `SHIFT_R_A:    op_res = DATA_W'($signed(bus.alu_a) >>> amt);
`endif
            default:       op_res = '0;
        endcase
    end

    // The first shift step is applied on the accept edge so a shift by N shows out_valid N cycles later.
    always_comb begin
        state_nx  = state;
        result_nx = result;
        work_nx   = work;
        cnt_nx    = cnt;
        funct_nx  = funct;
        case (state)
            IDLE, DONE: begin
                if (state == DONE && bus.out_ready) begin
                    state_nx = IDLE;
                end
                if (accept) begin
                    funct_nx = bus.alu_funct;
                    state_nx = DONE;
`ifdef EXU_ALU_FAST_SHIFT_EN
                    result_nx = op_res;
`else
                    if (is_shift && amt > SHAMT_W'(1)) begin
                        work_nx  = shift1(bus.alu_a, bus.alu_funct);
                        cnt_nx   = amt - SHAMT_W'(1);
                        state_nx = SHIFT;
                    end else if (is_shift) begin
                        result_nx = (amt == '0) ? bus.alu_a : shift1(bus.alu_a, bus.alu_funct);
                    end else begin
                        result_nx = op_res;
                    end
`endif
                end
            end
            SHIFT: begin
                work_nx = shift1(work, funct);
                cnt_nx  = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    result_nx = work_nx;
                    state_nx  = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            work   <= '0;
            cnt    <= '0;
            funct  <= '0;
        end else begin
            state  <= state_nx;
            result <= result_nx;
            work   <= work_nx;
            cnt    <= cnt_nx;
            funct  <= funct_nx;
        end
    end
endmodule

// File: tb/tb_exu_alu_seq.sv
// tb/tb_exu_alu_seq.sv - directed self-checking bench for exu_alu_seq
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`define NO_FUNCT     0
`define ADD          1
`define SUB          2
`define SHIFT_L_L    3
`define SHIFT_R_L    4
`define SHIFT_R_A    5
`define XOR          6
`define OR           7
`define AND          8
`define EQ           9
`define NEQ          10
`define LESS         11
`define GREATER_EQ   12
`define LESS_U       13
`define GREATER_EQ_U 14
`endif

module tb_exu_alu_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n;
    int   busy_cycles;

`ifdef EXU_ALU_FAST_SHIFT_EN
    localparam int SRA_LAT  = 1;
    localparam int SRA_BUSY = 0;
    localparam int SLL_LAT  = 1;
`else
    localparam int SRA_LAT  = 31;
    localparam int SRA_BUSY = 30;
    localparam int SLL_LAT  = 4;
`endif

    exu_alu_seq_if #(.DATA_W(32)) bus ();

    exu_alu_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid  = 1'b1;
        bus.alu_funct = f;
        bus.alu_a     = a;
        bus.alu_b     = b;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_funct = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result", bus.alu_result, 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        drive(`ADD, 32'hFFFF_FFFF, 32'h0000_0002);
        step();
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_result", bus.alu_result, 32'h0000_0001);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        drive(`SUB, 32'd5, 32'd7);
        step();
        chk("sub_valid", 32'(bus.out_valid), 32'd1);
        chk("sub_result", bus.alu_result, 32'hFFFF_FFFE);

        drive(`LESS, 32'hFFFF_FFFF, 32'h1);           step(); chk("less", bus.alu_result, 32'd1);
        drive(`LESS_U, 32'hFFFF_FFFF, 32'h1);         step(); chk("less_u", bus.alu_result, 32'd0);
        drive(`GREATER_EQ, 32'hFFFF_FFFF, 32'h1);     step(); chk("ge", bus.alu_result, 32'd0);
        drive(`GREATER_EQ_U, 32'h8000_0000, 32'h7FFF_FFFF); step(); chk("ge_u", bus.alu_result, 32'd1);
        drive(`EQ, 32'h1234, 32'h1234);               step(); chk("eq", bus.alu_result, 32'd1);
        drive(`NEQ, 32'h1234, 32'h1234);              step(); chk("neq", bus.alu_result, 32'd0);
        drive(`XOR, 32'hF0F0_1234, 32'h0FF0_FFFF);    step(); chk("xor", bus.alu_result, 32'hFF00_EDCB);
        drive(`OR, 32'hF000_0001, 32'h0000_0F00);     step(); chk("or", bus.alu_result, 32'hF000_0F01);
        drive(`AND, 32'hF0F0_1234, 32'h0FF0_FF00);    step(); chk("and", bus.alu_result, 32'h00F0_1200);
        drive(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   step(); chk("undef", bus.alu_result, 32'd0);
        drive(`SHIFT_L_L, 32'hABCD_0001, 32'hFFFF_FFE0); step(); chk("shift0", bus.alu_result, 32'hABCD_0001);
        bus.in_valid = 1'b0;
        step();
        chk("idle_after_take", 32'(bus.out_valid), 32'd0);

        drive(`SHIFT_R_A, 32'h8000_0000, 32'hFFFF_FFFF);
        step();
        bus.in_valid = 1'b0;
        n = 1;
        busy_cycles = 0;
        while (!bus.out_valid && n < 100) begin
            if (bus.busy) busy_cycles++;
            step();
            n++;
        end
        chk("sra_latency", 32'(n), 32'(SRA_LAT));
        chk("sra_busy_cycles", 32'(busy_cycles), 32'(SRA_BUSY));
        chk("sra_result", bus.alu_result, 32'hFFFF_FFFF);
        step();
        chk("sra_taken", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b0;
        drive(`SHIFT_L_L, 32'h1, 32'd4);
        step();
        drive(`ADD, 32'd7, 32'd7);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        chk("sll_latency", 32'(n), 32'(SLL_LAT));
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_result", bus.alu_result, 32'h0000_0010);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("release_valid", 32'(bus.out_valid), 32'd0);

        drive(`SHIFT_R_L, 32'hFFFF_FFFF, 32'd20);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midshift_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_result", bus.alu_result, 32'd0);
        busy_cycles = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.out_valid) busy_cycles++;
            step();
        end
        chk("midrst_no_output", 32'(busy_cycles), 32'd0);
        drive(`ADD, 32'd1, 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("post_rst_add_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_add", bus.alu_result, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
